// File: rtl/condicionador_botao.sv
// rtl/condicionador_botao.sv - push-button synchroniser, debouncer and one-shot press pulse generator
module condicionador_botao #(
   parameter logic [7:0] DEBOUNCE = 8'd4,
   parameter logic [7:0] HOLDOFF  = 8'd8
) (
   input  logic clk,
   input  logic rst,
   input  logic bt_in,
   output logic bt,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      HOLD     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       s1;
   logic       s2;
   logic       db;
   logic [7:0] cnt;
   logic [7:0] hcnt;

   // Two-flop synchroniser bringing the asynchronous button into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bt_in;
         s2 <= s1;
      end
   end

   // Debouncer: a new level must persist for DEBOUNCE consecutive samples; any sample matching db restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         db  <= 1'b0;
         cnt <= 8'd0;
      end else if (s2 == db) begin
         cnt <= 8'd0;
      end else if (cnt == DEBOUNCE - 8'd1) begin
         db  <= s2;
         cnt <= 8'd0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   // State register, hold-off counter and outputs registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hcnt  <= 8'd0;
         bt    <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         bt    <= (state_nxt == PULSE);
         busy  <= (state_nxt != IDLE);
         if (state == PULSE) begin
            hcnt <= HOLDOFF;
         end else if ((state == HOLD) && (hcnt != 8'd1)) begin
            hcnt <= hcnt - 8'd1;
         end
      end
   end

   // Next-state logic: one pulse per accepted press, then hold-off and wait for release
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (db) state_nxt = PULSE;
         end
         PULSE: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            if (hcnt == 8'd1) state_nxt = db ? WAIT_REL : IDLE;
         end
         WAIT_REL: begin
            if (!db) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_condicionador_botao.sv
// tb/tb_condicionador_botao.sv - directed self-checking bench for condicionador_botao
module tb_condicionador_botao;

   logic clk;
   logic rst;
   logic bt_in;
   logic bt;
   logic busy;

   int n_cmp;
   int n_err;

   condicionador_botao dut (
      .clk   (clk),
      .rst   (rst),
      .bt_in (bt_in),
      .bt    (bt),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(input int n);
      bt_in = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   // Release the button and check busy drops 6 edges after the first low sample
   task automatic release_check(input string tag);
      bt_in = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         tick();
         check($sformatf("%s_busy[%0d]", tag, k), busy, k < 6);
         check($sformatf("%s_bt[%0d]", tag, k), bt, 1'b0);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      bt_in = 1'b1;

      // Reset held two cycles with the button pressed
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("rst_bt[%0d]", i), bt, 1'b0);
         check($sformatf("rst_busy[%0d]", i), busy, 1'b0);
      end
      rst = 1'b0;
      for (int i = 0; i <= 15; i++) begin
         tick();
         check($sformatf("postrst_bt[%0d]", i), bt, i == 6);
         check($sformatf("postrst_busy[%0d]", i), busy, i >= 6);
      end
      release_check("postrst_rel");
      idle_gap(4);

      // Clean press: 20 high samples then low
      for (int i = 0; i <= 30; i++) begin
         bt_in = (i < 20);
         tick();
         check($sformatf("clean_bt[%0d]", i), bt, i == 6);
         check($sformatf("clean_busy[%0d]", i), busy, (i >= 6) && (i < 26));
      end
      idle_gap(4);

      // Glitch rejection: 3 high, 1 low, 3 high, then low
      for (int i = 0; i < 20; i++) begin
         bt_in = (i < 3) || ((i >= 4) && (i < 7));
         tick();
         check($sformatf("glitch_bt[%0d]", i), bt, 1'b0);
         check($sformatf("glitch_busy[%0d]", i), busy, 1'b0);
      end
      idle_gap(4);

      // Bouncy press: toggle for 6 samples, stable high 10, then low
      for (int i = 0; i < 26; i++) begin
         bt_in = (i < 6) ? (i % 2 == 0) : (i < 16);
         tick();
         check($sformatf("bouncy_bt[%0d]", i), bt, i == 12);
         check($sformatf("bouncy_busy[%0d]", i), busy, (i >= 12) && (i < 22));
      end
      idle_gap(4);

      // Press during hold-off: second press e9..e13 yields no pulse
      for (int i = 0; i < 20; i++) begin
         bt_in = (i < 5) || ((i >= 9) && (i < 14));
         tick();
         check($sformatf("hold_bt[%0d]", i), bt, i == 6);
         check($sformatf("hold_busy[%0d]", i), busy, (i >= 6) && (i < 20));
      end
      // Third press after busy has fallen
      for (int i = 0; i < 10; i++) begin
         bt_in = 1'b1;
         tick();
         check($sformatf("third_bt[%0d]", i), bt, i == 6);
         check($sformatf("third_busy[%0d]", i), busy, i >= 6);
      end
      release_check("third_rel");
      idle_gap(4);

      // Reset arriving on the pulse edge truncates it
      for (int i = 0; i < 6; i++) begin
         bt_in = 1'b1;
         tick();
         check($sformatf("midrst_pre_bt[%0d]", i), bt, 1'b0);
      end
      rst = 1'b1;
      tick();
      check("midrst_bt", bt, 1'b0);
      check("midrst_busy", busy, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("midrst_post_bt[%0d]", i), bt, i == 6);
         check($sformatf("midrst_post_busy[%0d]", i), busy, i >= 6);
      end
      release_check("midrst_rel");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
